// File: rtl/clk_div_multi_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg : shared constants and helpers for the multi-channel clock divider.
//   CW_DEF       default half-period counter/register width
//   DEF_HALF_DEF default reset half-period (output period = 2*DEF_HALF)
//   CW_MAX       widest half-period supported by max1()
//   max1(x)      clamps a half-period of 0 up to 1
// ----------------------------------------------------------------------------
package clkdiv_pkg;

   localparam int unsigned CW_DEF       = 32;
   localparam int unsigned DEF_HALF_DEF = 100;
   localparam int unsigned CW_MAX       = 64;

   // A half-period of 0 would never wrap; 1 is the fastest legal rate (CLK_IN/2).
   function automatic logic [CW_MAX-1:0] max1(input logic [CW_MAX-1:0] x);
      return (x == '0) ? CW_MAX'(1) : x;
   endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// ----------------------------------------------------------------------------
// clk_div_multi_if : control/status bus of clk_div_multi.
//   sync       realign all channels          en        per-channel run enable
//   div_wr     half-period write strobe      div_sel   addressed channel
//   div_data   half-period write value       div_rdata active half-period of div_sel
//   div_pend   shadow written, not applied   CLK_OUT   divided clocks
//   tick       one-cycle pulse on each CLK_OUT rising edge
// master drives control (system side), slave is the divider.
// ----------------------------------------------------------------------------
interface clk_div_multi_if
   import clkdiv_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = CW_DEF
);

   localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

   logic            sync;
   logic [NCH-1:0]  en;
   logic            div_wr;
   logic [SW-1:0]   div_sel;
   logic [CW-1:0]   div_data;
   logic [CW-1:0]   div_rdata;
   logic [NCH-1:0]  div_pend;
   logic [NCH-1:0]  CLK_OUT;
   logic [NCH-1:0]  tick;

   modport master (
      output sync, en, div_wr, div_sel, div_data,
      input  div_rdata, div_pend, CLK_OUT, tick
   );

   modport slave (
      input  sync, en, div_wr, div_sel, div_data,
      output div_rdata, div_pend, CLK_OUT, tick
   );

endinterface

// File: rtl/clk_div_multi_chan.sv
// ----------------------------------------------------------------------------
// clk_div_chan : one 50%-duty divider channel with glitch-free reprogramming.
//   CLK_IN    system clock            clr       async active-high reset
//   en_i      run enable              sync_i    phase realign (clears cnt/out)
//   wr_i      half-period write       data_i    half-period value
//   active_o  half-period in use      pend_o    shadow awaiting transfer
//   clk_o     divided clock           tick_o    pulse on clk_o rising edge
// ----------------------------------------------------------------------------
module clk_div_chan
   import clkdiv_pkg::*;
#(
   parameter int unsigned CW       = CW_DEF,
   parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
   input  logic          CLK_IN,
   input  logic          clr,
   input  logic          en_i,
   input  logic          sync_i,
   input  logic          wr_i,
   input  logic [CW-1:0] data_i,
   output logic [CW-1:0] active_o,
   output logic          pend_o,
   output logic          clk_o,
   output logic          tick_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] active_q, active_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic          pend_q, pend_d;
   logic          clk_q, clk_d;
   logic          tick_q, tick_d;
   logic          wrap;
   logic [CW-1:0] wdata;

   assign wrap  = en_i && (cnt_q == (active_q - CW'(1)));
   assign wdata = CW'(max1(CW_MAX'(data_i)));

   // Next state: sync beats write/transfer; new values land only on a wrap.
   always_comb begin
      cnt_d    = cnt_q;
      active_d = active_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      if (sync_i) begin
         cnt_d  = '0;
         clk_d  = 1'b0;
         pend_d = 1'b0;
         if (pend_q) begin
            active_d = shadow_q;
         end
      end else begin
         if (en_i) begin
            if (wrap) begin
               cnt_d  = '0;
               clk_d  = ~clk_q;
               tick_d = ~clk_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         if (wr_i) begin
            shadow_d = wdata;
            // A write landing on the wrap goes straight into use.
            if (wrap) begin
               active_d = wdata;
               pend_d   = 1'b0;
            end else begin
               pend_d = 1'b1;
            end
         end else if (wrap && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
         cnt_q    <= '0;
         active_q <= CW'(DEF_HALF);
         shadow_q <= CW'(DEF_HALF);
         pend_q   <= 1'b0;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
      end
   end

   assign active_o = active_q;
   assign pend_o   = pend_q;
   assign clk_o    = clk_q;
   assign tick_o   = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi : NCH independent programmable 50%-duty clock dividers.
//   CLK_IN  system clock
//   clr     async active-high reset (all channels back to DEF_HALF)
//   bus     clk_div_multi_if.slave control/status bus
// div_rdata is combinational from the addressed channel's active half-period.
// ----------------------------------------------------------------------------
module clk_div_multi
   import clkdiv_pkg::*;
#(
   parameter int unsigned NCH      = 4,
   parameter int unsigned CW       = CW_DEF,
   parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
   input  logic           CLK_IN,
   input  logic           clr,
   clk_div_multi_if.slave bus
);

   logic [CW-1:0] active_w [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic wr_c;
      logic pend_w, clk_w, tick_w;

      // Per-channel write decode; out-of-range selects hit nothing.
      assign wr_c = bus.div_wr && (32'(bus.div_sel) == 32'(i));

      clk_div_chan #(
         .CW       (CW),
         .DEF_HALF (DEF_HALF)
      ) u_chan (
         .CLK_IN   (CLK_IN),
         .clr      (clr),
         .en_i     (bus.en[i]),
         .sync_i   (bus.sync),
         .wr_i     (wr_c),
         .data_i   (bus.div_data),
         .active_o (active_w[i]),
         .pend_o   (pend_w),
         .clk_o    (clk_w),
         .tick_o   (tick_w)
      );

      assign bus.div_pend[i] = pend_w;
      assign bus.CLK_OUT[i]  = clk_w;
      assign bus.tick[i]     = tick_w;
   end

   // Readback mux; unmapped selects read as zero.
   always_comb begin
      bus.div_rdata = '0;
      if (32'(bus.div_sel) < NCH) begin
         bus.div_rdata = active_w[bus.div_sel];
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// ----------------------------------------------------------------------------
// tb_clk_div_multi : directed bench for clk_div_multi (NCH=4, CW=32, HALF=100).
// Cycle n counts rising edges of CLK_IN since clr was released; outputs are
// sampled 1 time unit after each edge.
// ----------------------------------------------------------------------------
module tb_clk_div_multi;

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 32;

   typedef struct {
      int       cyc;
      logic [3:0] clk_exp;
      logic [3:0] tick_exp;
   } vec_t;

   logic clk;
   logic clr;
   int   n;
   int   tick_cnt;
   int   total;
   int   passed;

   clk_div_multi_if #(.NCH(NCH), .CW(CW)) bus ();

   clk_div_multi #(
      .NCH      (NCH),
      .CW       (CW),
      .DEF_HALF (100)
   ) dut (
      .CLK_IN (clk),
      .clr    (clr),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s (n=%0d): got %0h, expected %0h", name, n, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
      tick_cnt += $countones(bus.tick);
   endtask

   task automatic run_to(input int target);
      while (n < target) step();
   endtask

   task automatic rd_chk(input string name, input int sel, input logic [31:0] exp);
      bus.div_sel = 2'(sel);
      #1;
      chk(name, bus.div_rdata, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n = 0;
      tick_cnt = 0;
   endtask

   vec_t t1 [12];
   vec_t t2 [10];

   initial begin
      t1 = '{
         '{1,   4'h0, 4'h0}, '{99,  4'h0, 4'h0}, '{100, 4'hF, 4'hF},
         '{101, 4'hF, 4'h0}, '{199, 4'hF, 4'h0}, '{200, 4'h0, 4'h0},
         '{201, 4'h0, 4'h0}, '{299, 4'h0, 4'h0}, '{300, 4'hF, 4'hF},
         '{301, 4'hF, 4'h0}, '{399, 4'hF, 4'h0}, '{400, 4'h0, 4'h0}
      };
      // ch1 half=3 from 100, ch2 half=5 from 100, ch0/ch3 still half=100
      t2 = '{
         '{101, 4'b1111, 4'b0000}, '{102, 4'b1111, 4'b0000},
         '{103, 4'b1101, 4'b0000}, '{104, 4'b1101, 4'b0000},
         '{105, 4'b1001, 4'b0000}, '{106, 4'b1011, 4'b0010},
         '{107, 4'b1011, 4'b0000}, '{108, 4'b1011, 4'b0000},
         '{109, 4'b1001, 4'b0000}, '{110, 4'b1101, 4'b0100}
      };

      total = 0; passed = 0; n = 0; tick_cnt = 0;
      clr = 1'b1;
      bus.sync = 1'b0; bus.en = '1; bus.div_wr = 1'b0;
      bus.div_sel = '0; bus.div_data = '0;

      // Reset state and default 200-cycle period
      @(negedge clk);
      #1;
      chk("rst_clk_out", 32'(bus.CLK_OUT), 0);
      chk("rst_tick", 32'(bus.tick), 0);
      chk("rst_pend", 32'(bus.div_pend), 0);
      rd_chk("rst_rdata0", 0, 100);
      do_reset();
      foreach (t1[k]) begin
         run_to(t1[k].cyc);
         chk("def_clk_out", 32'(bus.CLK_OUT), 32'(t1[k].clk_exp));
         chk("def_tick", 32'(bus.tick), 32'(t1[k].tick_exp));
      end
      chk("def_tick_total", tick_cnt, 8);

      // Pending reprogram of ch1, coincident write on ch2
      do_reset();
      run_to(40);
      bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_data = 32'd3;
      step();
      bus.div_wr = 1'b0;
      chk("reprog_pend_set", 32'(bus.div_pend), 32'b0010);
      rd_chk("reprog_rdata_old", 1, 100);
      run_to(99);
      chk("reprog_pend_hold", 32'(bus.div_pend), 32'b0010);
      chk("reprog_clk_pre", 32'(bus.CLK_OUT), 0);
      bus.div_wr = 1'b1; bus.div_sel = 2'd2; bus.div_data = 32'd5;
      step();
      bus.div_wr = 1'b0;
      chk("wrap_clk_out", 32'(bus.CLK_OUT), 32'hF);
      chk("wrap_tick", 32'(bus.tick), 32'hF);
      chk("wrap_pend_clear", 32'(bus.div_pend), 0);
      rd_chk("reprog_rdata_new", 1, 3);
      rd_chk("coinc_rdata", 2, 5);
      foreach (t2[k]) begin
         run_to(t2[k].cyc);
         chk("fast_clk_out", 32'(bus.CLK_OUT), 32'(t2[k].clk_exp));
         chk("fast_tick", 32'(bus.tick), 32'(t2[k].tick_exp));
         chk("coinc_no_pend", 32'(bus.div_pend), 0);
      end

      // Clamp of 0 to 1 on ch0, enable stall on ch0 and ch3
      do_reset();
      bus.div_wr = 1'b1; bus.div_sel = 2'd0; bus.div_data = 32'd0;
      step();
      bus.div_wr = 1'b0;
      chk("clamp_pend", 32'(bus.div_pend), 32'b0001);
      rd_chk("clamp_rdata_old", 0, 100);
      run_to(100);
      chk("clamp_rise", 32'(bus.CLK_OUT[0]), 1);
      rd_chk("clamp_rdata", 0, 1);
      step();
      chk("clamp_fall", 32'(bus.CLK_OUT[0]), 0);
      step();
      chk("clamp_rise2", 32'(bus.CLK_OUT[0]), 1);
      chk("clamp_tick", 32'(bus.tick[0]), 1);
      bus.en = 4'b0110;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("stall_clk_out", 32'({bus.CLK_OUT[3], bus.CLK_OUT[0]}), 32'b11);
         chk("stall_tick", 32'(bus.tick & 4'b1001), 0);
      end
      bus.en = '1;
      step();
      chk("resume_fall", 32'(bus.CLK_OUT[0]), 0);
      step();
      chk("resume_rise", 32'(bus.CLK_OUT[0]), 1);
      chk("resume_tick", 32'(bus.tick[0]), 1);
      run_to(200);
      chk("ref_ch2_fall", 32'(bus.CLK_OUT[2]), 0);
      chk("stall_ch3_hold", 32'(bus.CLK_OUT[3]), 1);
      run_to(206);
      chk("stall_ch3_late", 32'(bus.CLK_OUT[3]), 1);
      step();
      chk("stall_ch3_fall", 32'(bus.CLK_OUT[3]), 0);

      // Sync with ch3 pending, plus a write lost under sync
      bus.div_wr = 1'b1; bus.div_sel = 2'd3; bus.div_data = 32'd10;
      step();
      bus.div_wr = 1'b0;
      chk("sync_pre_pend", 32'(bus.div_pend), 32'b1000);
      run_to(209);
      chk("sync_pre_ch0", 32'(bus.CLK_OUT[0]), 1);
      bus.sync = 1'b1;
      bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_data = 32'd2;
      step();
      bus.sync = 1'b0; bus.div_wr = 1'b0;
      chk("sync_clk_out", 32'(bus.CLK_OUT), 0);
      chk("sync_tick", 32'(bus.tick), 0);
      chk("sync_pend", 32'(bus.div_pend), 0);
      rd_chk("sync_xfer", 3, 10);
      rd_chk("sync_lost_wr", 1, 100);
      step();
      chk("sync_ch0_rise", 32'(bus.CLK_OUT), 32'b0001);
      chk("sync_ch0_tick", 32'(bus.tick), 32'b0001);
      run_to(219);
      chk("sync_ch3_low", 32'(bus.CLK_OUT[3]), 0);
      step();
      chk("sync_ch3_rise", 32'(bus.CLK_OUT[3]), 1);
      chk("sync_ch3_tick", 32'(bus.tick[3]), 1);

      // Asynchronous clr while outputs are high
      bus.div_wr = 1'b1; bus.div_sel = 2'd2; bus.div_data = 32'd4;
      step();
      bus.div_wr = 1'b0;
      chk("clr_pre_pend", 32'(bus.div_pend), 32'b0100);
      run_to(225);
      chk("clr_pre_ch3", 32'(bus.CLK_OUT[3]), 1);
      #2;
      clr = 1'b1;
      #1;
      chk("clr_async_clk_out", 32'(bus.CLK_OUT), 0);
      chk("clr_async_pend", 32'(bus.div_pend), 0);
      rd_chk("clr_rdata0", 0, 100);
      rd_chk("clr_rdata2", 2, 100);
      rd_chk("clr_rdata3", 3, 100);
      clr = 1'b0;
      n = 0;
      run_to(99);
      chk("post_clr_low", 32'(bus.CLK_OUT), 0);
      step();
      chk("post_clr_rise", 32'(bus.CLK_OUT), 32'hF);
      chk("post_clr_tick", 32'(bus.tick), 32'hF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
